// File: rtl/square_seq_pkg.sv
// Shared widths, saturation constant and FSM encoding for the sequential squarer.
package square_seq_pkg;

    localparam int unsigned MAX_NUM  = 21;
    localparam int unsigned ACC_W    = 2 * MAX_NUM;
    localparam int unsigned SQ_STEPS = MAX_NUM;
    localparam int unsigned CNT_W    = $clog2(SQ_STEPS + 1);

    localparam logic [MAX_NUM-1:0] SQ_SAT = {MAX_NUM{1'b1}};

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_CALC = 2'd1,
        SQ_DONE = 2'd2
    } sq_state_t;

endpackage

// File: rtl/square_seq_if.sv
// Start/busy/done handshake between the calculator FSM and the squarer.
interface square_seq_if;
    import square_seq_pkg::*;

    logic               start;
    logic [MAX_NUM-1:0] x;
    logic               busy;
    logic               done;
    logic [MAX_NUM-1:0] y;
    logic               overflow;

    modport master (output start, output x, input busy, input done, input y, input overflow);
    modport slave  (input start, input x, output busy, output done, output y, output overflow);

endinterface

// File: rtl/square_seq.sv
// Radix-2 shift-add squarer: one multiplier bit per clock, saturating 21-bit result.
module square_seq
    import square_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    square_seq_if.slave  sq
);

    sq_state_t          state, state_n;
    logic [ACC_W-1:0]   mcand, mcand_n;
    logic [MAX_NUM-1:0] mplier, mplier_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [MAX_NUM-1:0] y_q, y_n;
    logic               ovf_q, ovf_n;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SQ_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            y_q    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            busy_q <= busy_n;
            done_q <= done_n;
            y_q    <= y_n;
            ovf_q  <= ovf_n;
        end
    end

    // Next-state, shift-add step and result capture
    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        mplier_n = mplier;
        acc_n    = acc;
        cnt_n    = cnt;
        busy_n   = busy_q;
        done_n   = 1'b0;
        y_n      = y_q;
        ovf_n    = ovf_q;

        case (state)
            SQ_IDLE: begin
                if (sq.start) begin
                    mcand_n  = ACC_W'(sq.x);
                    mplier_n = sq.x;
                    acc_n    = '0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = SQ_CALC;
                end
            end
            SQ_CALC: begin
                acc_n    = acc + (mplier[0] ? mcand : '0);
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + CNT_W'(1);
                // Result is taken from the post-step accumulator on the final step
                if (cnt == CNT_W'(SQ_STEPS - 1)) begin
                    state_n = SQ_DONE;
                    done_n  = 1'b1;
                    if (acc_n[ACC_W-1:MAX_NUM] != '0) begin
                        y_n   = SQ_SAT;
                        ovf_n = 1'b1;
                    end else begin
                        y_n   = acc_n[MAX_NUM-1:0];
                        ovf_n = 1'b0;
                    end
                end
            end
            SQ_DONE: begin
                busy_n  = 1'b0;
                state_n = SQ_IDLE;
            end
            default: begin
                state_n = SQ_IDLE;
            end
        endcase
    end

    assign sq.busy     = busy_q;
    assign sq.done     = done_q;
    assign sq.y        = y_q;
    assign sq.overflow = ovf_q;

endmodule

// File: doc/square_seq.md
# square_seq

Sequential integer squarer: the inverse of the design's combinational square-root block. It computes `y = x*x` for a `MAX_NUM`-bit (21-bit) unsigned operand with a radix-2 shift-add datapath, one multiplier bit per clock. Results that exceed `MAX_NUM` bits saturate and raise a flag. It sits beside the square-root unit in the arithmetic path, behind a start/busy/done handshake, so the calculator FSM can round-trip (square then root) without a wide combinational multiplier.

## Interface
- `MAX_NUM` — 21 (global `` `define `` from `Constants.vh`, not a module parameter) — operand and result width.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request; sampled only in IDLE.
- `x`  in  `MAX_NUM`  — unsigned operand; captured on the accepting edge.
- `busy`  out  1  — high in CALC and DONE.
- `done`  out  1  — one-cycle pulse; result valid.
- `y`  out  `MAX_NUM`  — squared result, saturated; held until the next `done`.
- `overflow`  out  1  — true product exceeded 2^21−1; updates with `y`.

## Operation
- Reset values: `busy`=0, `done`=0, `y`=0, `overflow`=0, state=IDLE, all internal registers 0.
- States:
  - IDLE: on `start`=1, load the multiplicand (`x`, zero-extended to 42 bits), the multiplier (`x`), the 42-bit accumulator (0) and the bit counter (0). Go to CALC.
  - CALC: each cycle, if multiplier bit0=1 then acc += multiplicand. Then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter. After the counter's 21st step (counter = 20 at the edge), go to DONE.
  - DONE: `done`=1 for exactly this cycle. Go to IDLE unconditionally.
- Result register update, on the CALC→DONE edge:
  - if acc[41:21] ≠ 0: `y` = 21'h1FFFFF and `overflow`=1;
  - else: `y` = acc[20:0] and `overflow`=0.
- Accumulator width is 42 bits; it never wraps.
- `start` is ignored in CALC and DONE. There is no queueing.
- `x` is ignored except on the accepting edge; changes to `x` mid-operation have no effect.
- `start` held continuously: the next operation is accepted in the IDLE cycle following DONE.
- Asynchronous reset in any state: immediate return to reset values. No `done` is issued for the aborted operation.
- Fixed latency regardless of operand value; no early termination.

## Timing
- Let edge k be the edge where `start`=1 is sampled in IDLE.
- `busy` rises after edge k.
- Edges k+1 … k+21 perform the 21 CALC steps.
- After edge k+21: state DONE, `done`=1, and `y`/`overflow` hold the new result.
- After edge k+22: `done`=0, `busy`=0, state IDLE.
- Accept-to-done latency is 21 cycles. Back-to-back throughput is one result per 23 cycles.
- `y`/`overflow` change only on the CALC→DONE edge or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `Constants.vh` already supplies `MAX_NUM`.
- Add to `Constants.vh`:
  - the state encodings `SQ_IDLE`/`SQ_CALC`/`SQ_DONE` (2 bits);
  - `SQ_STEPS` = `MAX_NUM`, used as the step count;
  - `SQ_SAT` = {`MAX_NUM`{1'b1}}.
- Single module. No sub-module is warranted: the shift-add step is one adder and two shifters inline.

## Test plan
- After reset, hold `start`=0 → `busy`=0, `done`=0, `y`=0, `overflow`=0 indefinitely.
- `x`=9 with a 1-cycle `start` at edge k → `done` high only in the cycle after edge k+21, with `y`=81 and `overflow`=0. `busy` is high after edges k…k+21.
- `x`=0 → `y`=0, `overflow`=0, same 21-cycle latency. Then `x`=1448 → `y`=2096704, `overflow`=0 (largest non-saturating input).
- `x`=1449 → `y`=2097151 and `overflow`=1. Then `x`=2097151 → `y`=2097151 and `overflow`=1. Then `x`=3 → `y`=9 and `overflow` clears.
- `start` pulsed with `x`=100 mid-CALC of `x`=5, and `x` changed every cycle → single `done` with `y`=25. The second request is dropped.
- Assert `rst` asynchronously (off-edge) at CALC step 10 of `x`=7 → outputs go to 0 immediately and no `done` follows. Then `start` with `x`=12 → `y`=144 after 21 cycles.
